// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one fixed-latency multiplier core among
// N_REQ requesters, with credit-protected per-requester result FIFOs.
module mult_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      res_valid,
  input  logic [N_REQ-1:0]      res_ready,
  output logic [64*N_REQ-1:0]   res_p,
  output logic [31:0]           core_a,
  output logic [31:0]           core_b,
  output logic                  core_en,
  input  logic [63:0]           core_p,
  output logic                  busy
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [LAT-1:0] tag_v_q;
  logic [IDW-1:0] tag_id_q [LAT];
  logic [CW-1:0]  cnt_q    [N_REQ];
  logic [CW-1:0]  occ_q    [N_REQ];
  logic [PW-1:0]  wptr_q   [N_REQ];
  logic [PW-1:0]  rptr_q   [N_REQ];
  logic [63:0]    mem_q    [N_REQ][DEPTH];

  logic [N_REQ-1:0] elig, gnt, wr, pop;
  logic [IDW-1:0]   gidx;
  logic             found;
  logic             issue;
  int unsigned      idx;

  // A requester may issue only while it holds a free result slot (credit).
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CW'(DEPTH));
    end
  end

  // Round-robin search starting at ptr_q.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && elig[IDW'(idx)]) begin
        found = 1'b1;
        gidx  = IDW'(idx);
      end
    end
    if (found) gnt[gidx] = 1'b1;
  end

  assign issue     = found && rst_n;
  assign req_ready = gnt & {N_REQ{rst_n}};
  assign core_en   = issue;
  assign core_a    = issue ? req_a[32*gidx +: 32] : '0;
  assign core_b    = issue ? req_b[32*gidx +: 32] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (gidx == IDW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
  end

  // FIFO status, pops and tag-steered writes.
  always_comb begin
    wr        = '0;
    pop       = '0;
    res_valid = '0;
    res_p     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      res_valid[i]      = (occ_q[i] != '0);
      pop[i]            = res_valid[i] && res_ready[i];
      wr[i]             = tag_v_q[LAT-1] && (tag_id_q[LAT-1] == IDW'(i));
      res_p[64*i +: 64] = mem_q[i][rptr_q[i]];
    end
  end

  always_comb begin
    busy = |tag_v_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      tag_v_q <= '0;
      for (int s = 0; s < LAT; s++) tag_id_q[s] <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i]  <= '0;
        occ_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      tag_v_q[0]  <= issue;
      tag_id_q[0] <= gidx;
      for (int s = 1; s < LAT; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!req_ready[i] && pop[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
        if (wr[i] && !pop[i])      occ_q[i] <= occ_q[i] + 1'b1;
        else if (!wr[i] && pop[i]) occ_q[i] <= occ_q[i] - 1'b1;
        if (wr[i])  wptr_q[i] <= (wptr_q[i] == PW'(DEPTH - 1)) ? '0 : wptr_q[i] + 1'b1;
        if (pop[i]) rptr_q[i] <= (rptr_q[i] == PW'(DEPTH - 1)) ? '0 : rptr_q[i] + 1'b1;
      end
    end
  end

  // Product storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (wr[i]) mem_q[i][wptr_q[i]] <= core_p;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with literal expected values.
module tb_mult_arbiter;
  localparam int N   = 4;
  localparam int LAT = 4;
  localparam int DEP = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, res_valid, res_ready;
  logic [32*N-1:0]  req_a, req_b;
  logic [64*N-1:0]  res_p;
  logic [31:0]      core_a, core_b;
  logic             core_en, busy;
  logic [63:0]      core_p;

  int errors = 0;
  int checks = 0;

  mult_arbiter #(.N_REQ(N), .LAT(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
    .core_a(core_a), .core_b(core_b), .core_en(core_en), .core_p(core_p),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier core stand-in: plain signed product delayed LAT cycles.
  logic [63:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= 64'(longint'($signed(core_a)) * longint'($signed(core_b)));
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign core_p = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-requester result queues plus an in-flight list.
  typedef struct { int id; logic [63:0] prod; int due; } fl_t;
  fl_t         inflight[$];
  logic [63:0] mq [N][$];
  int          m_ptr = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    int g, used, j;
    logic [N-1:0] exp_rv, exp_rdy;
    logic exp_busy;
    logic [31:0] ea, eb;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_res_valid", 64'(res_valid), 64'(0));
      chk("rst_core_en", 64'(core_en), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      inflight.delete();
      for (int i = 0; i < N; i++) mq[i].delete();
      m_ptr = 0;
    end else begin
      exp_rv = '0;
      exp_busy = (inflight.size() != 0);
      for (int i = 0; i < N; i++) begin
        if (mq[i].size() > 0) begin
          exp_rv[i] = 1'b1;
          exp_busy = 1'b1;
          chk("model_res_p", res_p[64*i +: 64], mq[i][0]);
        end
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        used = mq[j].size();
        foreach (inflight[q]) if (inflight[q].id == j) used++;
        if (g < 0 && req_valid[j] && used < DEP) g = j;
      end
      exp_rdy = '0;
      ea = '0;
      eb = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea = req_a[32*g +: 32];
        eb = req_b[32*g +: 32];
      end
      chk("model_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("model_core_en", 64'(core_en), 64'(g >= 0));
      chk("model_core_a", 64'(core_a), 64'(ea));
      chk("model_core_b", 64'(core_b), 64'(eb));
      chk("model_res_valid", 64'(res_valid), 64'(exp_rv));
      chk("model_busy", 64'(busy), 64'(exp_busy));
      // advance to next cycle: pops, then arrivals, then the new issue
      for (int i = 0; i < N; i++)
        if (mq[i].size() > 0 && res_ready[i]) void'(mq[i].pop_front());
      while (inflight.size() > 0 && inflight[0].due == cyc) begin
        fl_t f;
        f = inflight.pop_front();
        chk("fifo_no_overflow", 64'(mq[f.id].size() < DEP), 64'(1));
        mq[f.id].push_back(f.prod);
      end
      if (g >= 0) begin
        fl_t f;
        f.id = g;
        f.prod = 64'(longint'($signed(ea)) * longint'($signed(eb)));
        f.due = cyc + LAT;
        inflight.push_back(f);
        m_ptr = (g + 1) % N;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, g, nres;
    int cnt_g[N];
    logic [63:0] got[6];
    longint exp_t[6];
    exp_t = '{-33, -72, -125, -192, -273, -368};
    rst_n = 1'b0;
    req_valid = '0;
    res_ready = '0;
    req_a = '0;
    req_b = '0;

    // Single op on requester 2
    do_reset();
    set_op(2, 32'h0000_0007, 32'hFFFF_FFFD);
    req_valid = 4'b0100;
    sample();
    chk("t1_ready", 64'(req_ready), 64'(4'b0100));
    chk("t1_core_en", 64'(core_en), 64'(1));
    chk("t1_core_a", 64'(core_a), 64'(7));
    tick();
    req_valid = '0;
    for (int k = 1; k <= LAT; k++) begin
      sample();
      chk("t1_not_yet_valid", 64'(res_valid[2]), 64'(0));
      tick();
    end
    sample();
    chk("t1_valid", 64'(res_valid[2]), 64'(1));
    chk("t1_product", res_p[2*64 +: 64], 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    res_ready = 4'b0100;
    tick();
    res_ready = '0;

    // Fairness with all requesters valid
    do_reset();
    res_ready = '1;
    req_valid = '1;
    for (int i = 0; i < N; i++) cnt_g[i] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
      sample();
      g = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      chk("fair_order", 64'(g), 64'(k % N));
      if (g >= 0) cnt_g[g]++;
      tick();
    end
    req_valid = '0;
    repeat (LAT + 3) tick();
    for (int i = 0; i < N; i++) chk("fair_count", 64'(cnt_g[i]), 64'(2));

    // Credit backpressure on requester 0
    do_reset();
    set_op(0, 32'h0000_0003, 32'h0000_0005);
    req_valid = 4'b0001;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      sample();
      if (req_ready[0]) n++;
      tick();
    end
    chk("bp_issues", 64'(n), 64'(2));
    res_ready = 4'b0001;
    sample();
    chk("bp_blocked_during_pop", 64'(req_ready[0]), 64'(0));
    tick();
    res_ready = '0;
    sample();
    chk("bp_reissue", 64'(req_ready[0]), 64'(1));
    tick();
    n = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      if (req_ready[0]) n++;
      tick();
    end
    chk("bp_after", 64'(n), 64'(0));
    req_valid = '0;
    res_ready = 4'b0001;
    repeat (LAT + 4) tick();
    res_ready = '0;
    sample();
    chk("bp_drained_busy", 64'(busy), 64'(0));
    tick();

    // Streaming on requester 1 with simultaneous push and pop
    do_reset();
    res_ready = 4'b0010;
    req_valid = 4'b0010;
    n = 0;
    nres = 0;
    set_op(1, 32'(-3), 32'(11));
    for (int k = 0; k < 60 && nres < 6; k++) begin
      sample();
      if (res_valid[1]) begin
        got[nres] = res_p[64 +: 64];
        nres++;
      end
      if (req_ready[1]) n++;
      tick();
      if (n < 6) set_op(1, 32'(-(n + 3)), 32'(n * 7 + 11));
      else req_valid = '0;
    end
    chk("stream_count", 64'(nres), 64'(6));
    for (int j = 0; j < 6; j++) chk("stream_order", got[j], 64'(exp_t[j]));
    res_ready = '0;

    // Reset with three operations in flight
    do_reset();
    req_valid = '1;
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 2), 32'(i + 9));
    repeat (3) begin
      sample();
      tick();
    end
    req_valid = '0;
    sample();
    chk("mid_busy_before", 64'(busy), 64'(1));
    tick();
    rst_n = 1'b0;
    sample();
    chk("mid_rst_res_valid", 64'(res_valid), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < LAT + 2; k++) begin
      sample();
      if (res_valid != '0) n++;
      tick();
    end
    chk("post_rst_quiet", 64'(n), 64'(0));

    // Extreme operands
    do_reset();
    set_op(0, 32'h8000_0000, 32'h8000_0000);
    set_op(3, 32'h7FFF_FFFF, 32'h8000_0000);
    req_valid = 4'b1001;
    sample();
    chk("ext_grant0", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = 4'b1000;
    sample();
    chk("ext_grant3", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = '0;
    repeat (LAT) tick();
    sample();
    chk("ext_valid", 64'(res_valid), 64'(4'b1001));
    chk("ext_min_min", res_p[0 +: 64], 64'h4000_0000_0000_0000);
    chk("ext_max_min", res_p[3*64 +: 64], 64'hC000_0000_8000_0000);
    tick();
    res_ready = '1;
    repeat (3) tick();
    sample();
    chk("final_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
